// File: rtl/sdram_owner_pkg.sv
// Shared types for the SDRAM ownership sequencer.
// State encoding and error-bit positions.
package sdram_owner_pkg;

  typedef enum logic [2:0] {
    S_CAM   = 3'd0,
    S_DRAIN = 3'd1,
    S_REQ   = 3'd2,
    S_NIOS  = 3'd3,
    S_REL   = 3'd4
  } state_e;

  localparam int ERR_DRAIN = 0;
  localparam int ERR_HS    = 1;

endpackage

// File: rtl/sdram_owner_sequencer_if.sv
// Control/status bundle between Nios PIO, camera
// controller, arbiter and the ownership sequencer.
interface sdram_owner_sequencer_if;
  logic        nios_req;
  logic        cam_idle;
  logic        NiosHasControl;
  logic        CamHasControl;
  logic        err_clr;
  logic        RequestNiosControl;
  logic        cam_pause;
  logic        nios_grant;
  logic        busy;
  logic [1:0]  err;
  logic [15:0] grant_count;

  modport master (
    output nios_req, cam_idle,
    output NiosHasControl, CamHasControl,
    output err_clr,
    input  RequestNiosControl, cam_pause,
    input  nios_grant, busy, err, grant_count
  );

  modport slave (
    input  nios_req, cam_idle,
    input  NiosHasControl, CamHasControl,
    input  err_clr,
    output RequestNiosControl, cam_pause,
    output nios_grant, busy, err, grant_count
  );
endinterface

// File: rtl/sdram_owner_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear.
// o_hit flags the enabled cycle that reaches MAX.
module sat_counter #(
  parameter int MAX = 15
) (
  input  logic                       clk,
  input  logic                       Reset_N,
  input  logic                       i_clr,
  input  logic                       i_en,
  output logic [$clog2(MAX+1)-1:0]   o_q,
  output logic                       o_at_max,
  output logic                       o_hit
);
  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_en && !o_at_max) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign o_q      = r_q;
  assign o_at_max = (r_q == W'(MAX));
  assign o_hit    = i_en && (r_q == W'(MAX - 1));
endmodule

// File: rtl/sdram_owner_sequencer.sv
// Hands SDRAM ownership between camera and Nios:
// drain camera, handshake arbiter, hold, release.
module sdram_owner_sequencer
  import sdram_owner_pkg::*;
#(
  parameter int IDLE_WAIT_MAX  = 4096,
  parameter int SWITCH_TIMEOUT = 64,
  parameter int MIN_HOLD       = 16
) (
  input logic                     clk,
  input logic                     Reset_N,
  sdram_owner_sequencer_if.slave  sq
);
  localparam int DW = $clog2(IDLE_WAIT_MAX + 1);
  localparam int TW = $clog2(SWITCH_TIMEOUT + 1);
  localparam int HW = $clog2(MIN_HOLD + 1);

  state_e      r_state, w_next;
  logic        w_chg;
  logic [1:0]  w_set;
  logic        r_idle_d, r_rearm;
  logic [1:0]  r_err;
  logic        r_req, r_pause, r_grant, r_busy;
  logic        w_req, w_pause, w_grant, w_busy;

  logic [DW-1:0] w_drain_q;
  logic [TW-1:0] w_hs_q;
  logic [HW-1:0] w_hold_q;
  logic [15:0]   w_gc_q;
  logic w_drain_max, w_drain_hit;
  logic w_hs_max, w_hs_hit;
  logic w_hold_max, w_hold_hit;
  logic w_gc_max, w_gc_hit;
  logic w_nios_exit;
  logic w_unused;

  assign w_chg       = (w_next != r_state);
  assign w_nios_exit = (r_state == S_NIOS) && (w_next == S_REL);

  sat_counter #(.MAX(IDLE_WAIT_MAX)) u_drain (
    .clk(clk), .Reset_N(Reset_N),
    .i_clr(w_chg), .i_en(r_state == S_DRAIN),
    .o_q(w_drain_q), .o_at_max(w_drain_max),
    .o_hit(w_drain_hit)
  );

  sat_counter #(.MAX(SWITCH_TIMEOUT)) u_hs (
    .clk(clk), .Reset_N(Reset_N),
    .i_clr(w_chg),
    .i_en((r_state == S_REQ) || (r_state == S_REL)),
    .o_q(w_hs_q), .o_at_max(w_hs_max),
    .o_hit(w_hs_hit)
  );

  sat_counter #(.MAX(MIN_HOLD)) u_hold (
    .clk(clk), .Reset_N(Reset_N),
    .i_clr(w_chg), .i_en(r_state == S_NIOS),
    .o_q(w_hold_q), .o_at_max(w_hold_max),
    .o_hit(w_hold_hit)
  );

  sat_counter #(.MAX(65535)) u_gcnt (
    .clk(clk), .Reset_N(Reset_N),
    .i_clr(1'b0), .i_en(w_nios_exit),
    .o_q(w_gc_q), .o_at_max(w_gc_max),
    .o_hit(w_gc_hit)
  );

  assign w_unused = ^{w_drain_q, w_drain_max, w_hs_q,
                      w_hs_max, w_hold_max, w_hold_hit,
                      w_gc_max, w_gc_hit};

  // Arbiter resets with the Nios owning SDRAM.
  always_ff @(posedge clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_state  <= S_REL;
      r_idle_d <= 1'b0;
      r_rearm  <= 1'b1;
      r_err    <= 2'b00;
      r_req    <= 1'b0;
      r_pause  <= 1'b1;
      r_grant  <= 1'b0;
      r_busy   <= 1'b1;
    end else begin
      r_state  <= w_next;
      r_idle_d <= (r_state == S_DRAIN) && !w_chg
                  && sq.cam_idle;
      if (w_set[ERR_DRAIN]) begin
        r_rearm <= 1'b0;
      end else if (!sq.nios_req) begin
        r_rearm <= 1'b1;
      end
      r_err   <= w_set | (r_err & ~{2{sq.err_clr}});
      r_req   <= w_req;
      r_pause <= w_pause;
      r_grant <= w_grant;
      r_busy  <= w_busy;
    end
  end

  always_comb begin
    w_next = r_state;
    w_set  = 2'b00;
    unique case (r_state)
      S_CAM: begin
        if (sq.nios_req && r_rearm) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (!sq.nios_req) begin
          w_next = S_CAM;
        end else if (w_drain_hit) begin
          w_next = S_CAM;
          w_set[ERR_DRAIN] = 1'b1;
        end else if (sq.cam_idle && r_idle_d) begin
          w_next = S_REQ;
        end
      end
      S_REQ: begin
        if (sq.NiosHasControl) begin
          w_next = S_NIOS;
        end else if (w_hs_hit) begin
          w_set[ERR_HS] = 1'b1;
        end
      end
      S_NIOS: begin
        if (!sq.nios_req && w_hold_q >= HW'(MIN_HOLD - 1))
          w_next = S_REL;
      end
      S_REL: begin
        if (sq.CamHasControl) begin
          w_next = S_CAM;
        end else if (w_hs_hit) begin
          w_set[ERR_HS] = 1'b1;
        end
      end
      default: w_next = S_REL;
    endcase
    w_pause = (w_next != S_CAM);
    w_req   = (w_next == S_REQ) || (w_next == S_NIOS);
    w_grant = (w_next == S_NIOS);
    w_busy  = (w_next == S_DRAIN) || (w_next == S_REQ)
              || (w_next == S_REL);
  end

  assign sq.RequestNiosControl = r_req;
  assign sq.cam_pause          = r_pause;
  assign sq.nios_grant         = r_grant;
  assign sq.busy               = r_busy;
  assign sq.err                = r_err;
  assign sq.grant_count        = w_gc_q;
endmodule
